// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: incoming MEM-stage instruction, load response, and
// writeback/forwarding/stall outputs.
interface mem_wb_stage_if #(
    parameter int N    = 5,
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_flush;
    logic            in_reg_write;
    logic            in_is_load;
    logic [1:0]      in_wb_sel;
    logic [2:0]      in_funct3;
    logic [N-1:0]    in_rd;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_pc_plus4;
    logic [XLEN-1:0] in_imm;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            stall_req;
    logic            wb_reg_write;
    logic [N-1:0]    wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            fwd_valid;
    logic            err_timeout;

    modport master (
        output in_valid, in_flush, in_reg_write, in_is_load, in_wb_sel, in_funct3,
               in_rd, in_alu_result, in_pc_plus4, in_imm, mem_rsp_valid, mem_rsp_data,
        input  stall_req, wb_reg_write, wb_rd, wb_data, fwd_valid, err_timeout
    );

    modport slave (
        input  in_valid, in_flush, in_reg_write, in_is_load, in_wb_sel, in_funct3,
               in_rd, in_alu_result, in_pc_plus4, in_imm, mem_rsp_valid, mem_rsp_data,
        output stall_req, wb_reg_write, wb_rd, wb_data, fwd_valid, err_timeout
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: waits for load responses,
// formats load data, selects the writeback source and drives the regfile port.
module mem_wb_stage #(
    parameter int N        = 5,
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);
    typedef enum logic {S_IDLE, S_WAIT_RSP} state_t;

    localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_wait_cnt, w_wait_cnt_nxt;
    logic [N-1:0]    r_ld_rd, w_ld_rd_nxt;
    logic            r_ld_we, w_ld_we_nxt;
    logic [2:0]      r_ld_f3, w_ld_f3_nxt;
    logic [1:0]      r_ld_off, w_ld_off_nxt;
    logic            r_wb_we, w_wb_we_nxt;
    logic [N-1:0]    r_wb_rd, w_wb_rd_nxt;
    logic [XLEN-1:0] r_wb_data, w_wb_data_nxt;
    logic            r_err, w_err_nxt;
    logic            w_accept;

    function automatic logic [XLEN-1:0] f_format(input logic [2:0] f3,
                                                 input logic [1:0] off,
                                                 input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    assign w_accept = bus.in_valid & ~bus.in_flush & (r_state == S_IDLE);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_ld_rd_nxt    = r_ld_rd;
        w_ld_we_nxt    = r_ld_we;
        w_ld_f3_nxt    = r_ld_f3;
        w_ld_off_nxt   = r_ld_off;
        w_wb_we_nxt    = 1'b0;
        w_wb_rd_nxt    = r_wb_rd;
        w_wb_data_nxt  = r_wb_data;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.in_is_load && !bus.mem_rsp_valid) begin
                        w_ld_rd_nxt    = bus.in_rd;
                        w_ld_we_nxt    = bus.in_reg_write;
                        w_ld_f3_nxt    = bus.in_funct3;
                        w_ld_off_nxt   = bus.in_alu_result[1:0];
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = S_WAIT_RSP;
                    end else begin
                        w_wb_rd_nxt = bus.in_rd;
                        w_wb_we_nxt = bus.in_reg_write & (bus.in_rd != '0);
                        if (bus.in_is_load) begin
                            w_wb_data_nxt = f_format(bus.in_funct3, bus.in_alu_result[1:0],
                                                     bus.mem_rsp_data);
                        end else begin
                            // The load code on a non-load falls back to the ALU result.
                            case (bus.in_wb_sel)
                                2'b10:   w_wb_data_nxt = bus.in_pc_plus4;
                                2'b11:   w_wb_data_nxt = bus.in_imm;
                                default: w_wb_data_nxt = bus.in_alu_result;
                            endcase
                        end
                    end
                end
            end
            S_WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    w_wb_rd_nxt   = r_ld_rd;
                    w_wb_we_nxt   = r_ld_we & (r_ld_rd != '0);
                    w_wb_data_nxt = f_format(r_ld_f3, r_ld_off, bus.mem_rsp_data);
                    w_state_nxt   = S_IDLE;
                end else if (r_wait_cnt == LP_LAST) begin
                    w_err_nxt      = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_ld_rd    <= '0;
            r_ld_we    <= 1'b0;
            r_ld_f3    <= '0;
            r_ld_off   <= '0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_ld_rd    <= w_ld_rd_nxt;
            r_ld_we    <= w_ld_we_nxt;
            r_ld_f3    <= w_ld_f3_nxt;
            r_ld_off   <= w_ld_off_nxt;
            r_wb_we    <= w_wb_we_nxt;
            r_wb_rd    <= w_wb_rd_nxt;
            r_wb_data  <= w_wb_data_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.stall_req    = (r_state == S_WAIT_RSP);
    assign bus.wb_reg_write = r_wb_we;
    assign bus.fwd_valid    = r_wb_we;
    assign bus.wb_rd        = r_wb_rd;
    assign bus.wb_data      = r_wb_data;
    assign bus.err_timeout  = r_err;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural writeback model.
module tb_mem_wb_stage;
    localparam int N        = 5;
    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.N(N), .XLEN(XLEN)) u_bus ();

    mem_wb_stage #(.N(N), .XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: one outstanding load and the expected register-file port.
    bit          m_busy;
    int          m_waited;
    logic [4:0]  m_rd;
    bit          m_rw;
    logic [2:0]  m_f3;
    int          m_off;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] w);
        int unsigned v;
        case (f3)
            3'd0: begin v = (w >> (8 * off)) & 32'hFF;
                        return (v >= 128) ? v - 256 : v; end
            3'd4: return (w >> (8 * off)) & 32'hFF;
            3'd1: begin v = (w >> (16 * (off / 2))) & 32'hFFFF;
                        return (v >= 32768) ? v - 65536 : v; end
            3'd5: return (w >> (16 * (off / 2))) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_busy = 0; m_waited = 0;
            e_we = 0; e_rd = 0; e_data = 0; e_err = 0;
            return;
        end
        e_we  = 0;
        e_err = 0;
        if (!m_busy) begin
            if (u_bus.in_valid && !u_bus.in_flush) begin
                if (u_bus.in_is_load && !u_bus.mem_rsp_valid) begin
                    m_busy = 1; m_waited = 0;
                    m_rd = u_bus.in_rd; m_rw = u_bus.in_reg_write;
                    m_f3 = u_bus.in_funct3; m_off = int'(u_bus.in_alu_result % 4);
                end else begin
                    e_rd = u_bus.in_rd;
                    e_we = u_bus.in_reg_write && (u_bus.in_rd != 0);
                    if (u_bus.in_is_load)
                        e_data = m_load(u_bus.in_funct3, int'(u_bus.in_alu_result % 4),
                                        u_bus.mem_rsp_data);
                    else if (u_bus.in_wb_sel == 2)
                        e_data = u_bus.in_pc_plus4;
                    else if (u_bus.in_wb_sel == 3)
                        e_data = u_bus.in_imm;
                    else
                        e_data = u_bus.in_alu_result;
                end
            end
        end else begin
            m_waited++;
            if (u_bus.mem_rsp_valid) begin
                m_busy = 0;
                e_rd   = m_rd;
                e_we   = m_rw && (m_rd != 0);
                e_data = m_load(m_f3, m_off, u_bus.mem_rsp_data);
            end else if (m_waited == MAX_WAIT) begin
                m_busy = 0;
                e_err  = 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("wb_reg_write", 32'(u_bus.wb_reg_write), 32'(e_we));
        check("fwd_valid",    32'(u_bus.fwd_valid),    32'(e_we));
        check("err_timeout",  32'(u_bus.err_timeout),  32'(e_err));
        check("stall_req",    32'(u_bus.stall_req),    32'(m_busy));
        check("wb_rd",        32'(u_bus.wb_rd),        32'(e_rd));
        check("wb_data",      u_bus.wb_data,           e_data);
    endtask

    task automatic drv_none();
        u_bus.in_valid      = 1'b0;
        u_bus.in_flush      = 1'b0;
        u_bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic drv_instr(input logic ld, input logic [1:0] sel, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [31:0] alu);
        u_bus.in_valid      = 1'b1;
        u_bus.in_flush      = 1'b0;
        u_bus.in_reg_write  = 1'b1;
        u_bus.in_is_load    = ld;
        u_bus.in_wb_sel     = sel;
        u_bus.in_funct3     = f3;
        u_bus.in_rd         = rd;
        u_bus.in_alu_result = alu;
    endtask

    logic [2:0]  fmt_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  fmt_off [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [31:0] fmt_exp [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80F1,
                                 32'h00007F01, 32'h80F17F01};

    initial begin
        int stall_cycles;
        rst = 1'b0;
        drv_instr(1'b0, 2'b00, 3'd2, 5'd1, 32'h1);
        u_bus.in_pc_plus4   = 32'h0000_0104;
        u_bus.in_imm        = 32'hABCD_E000;
        u_bus.mem_rsp_valid = 1'b0;
        u_bus.mem_rsp_data  = 32'h0;

        // Reset held with a valid instruction present.
        tick();
        tick();
        check("rst_we", 32'(u_bus.wb_reg_write), 32'h0);
        check("rst_stall", 32'(u_bus.stall_req), 32'h0);

        rst = 1'b1;
        drv_instr(1'b0, 2'b00, 3'd0, 5'd5, 32'h1234);
        tick();
        check("alu_we", 32'(u_bus.wb_reg_write), 32'h1);
        check("alu_rd", 32'(u_bus.wb_rd), 32'd5);
        check("alu_data", u_bus.wb_data, 32'h0000_1234);

        drv_instr(1'b0, 2'b00, 3'd0, 5'd0, 32'hFFFF);
        tick();
        check("x0_we", 32'(u_bus.wb_reg_write), 32'h0);
        check("x0_fwd", 32'(u_bus.fwd_valid), 32'h0);

        drv_instr(1'b0, 2'b10, 3'd0, 5'd6, 32'h55);
        tick();
        check("pc4_data", u_bus.wb_data, 32'h0000_0104);
        drv_instr(1'b0, 2'b11, 3'd0, 5'd6, 32'h55);
        tick();
        check("imm_data", u_bus.wb_data, 32'hABCD_E000);
        drv_instr(1'b0, 2'b01, 3'd0, 5'd6, 32'h77);
        tick();
        check("sel01_alu", u_bus.wb_data, 32'h0000_0077);

        // Same-cycle load responses through every format.
        u_bus.mem_rsp_valid = 1'b1;
        u_bus.mem_rsp_data  = 32'h80F1_7F01;
        for (int i = 0; i < 5; i++) begin
            drv_instr(1'b1, 2'b01, fmt_f3[i], 5'd3, {30'h400, fmt_off[i]});
            tick();
            check("fmt_data", u_bus.wb_data, fmt_exp[i]);
            check("fmt_stall", 32'(u_bus.stall_req), 32'h0);
        end

        // Load waits three cycles while another instruction is held upstream.
        drv_instr(1'b1, 2'b01, 3'd2, 5'd7, 32'h2000);
        u_bus.mem_rsp_valid = 1'b0;
        tick();
        check("stall_c1", 32'(u_bus.stall_req), 32'h1);
        drv_instr(1'b0, 2'b00, 3'd0, 5'd9, 32'h99);
        tick();
        check("stall_c2", 32'(u_bus.stall_req), 32'h1);
        tick();
        check("stall_c3", 32'(u_bus.stall_req), 32'h1);
        u_bus.mem_rsp_valid = 1'b1;
        u_bus.mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        check("rsp_data", u_bus.wb_data, 32'hDEAD_BEEF);
        check("rsp_rd", 32'(u_bus.wb_rd), 32'd7);
        check("rsp_stall", 32'(u_bus.stall_req), 32'h0);
        u_bus.mem_rsp_valid = 1'b0;
        tick();
        check("held_rd", 32'(u_bus.wb_rd), 32'd9);
        check("held_data", u_bus.wb_data, 32'h0000_0099);

        // Timeout with no response, then a late response.
        drv_instr(1'b1, 2'b01, 3'd2, 5'd10, 32'h3000);
        tick();
        drv_none();
        stall_cycles = 0;
        while (u_bus.stall_req && stall_cycles < 40) begin
            stall_cycles++;
            tick();
        end
        check("to_len", 32'(stall_cycles), 32'(MAX_WAIT));
        check("to_err", 32'(u_bus.err_timeout), 32'h1);
        check("to_we", 32'(u_bus.wb_reg_write), 32'h0);
        u_bus.mem_rsp_valid = 1'b1;
        tick();
        check("to_pulse", 32'(u_bus.err_timeout), 32'h0);
        check("late_we", 32'(u_bus.wb_reg_write), 32'h0);

        // Reset during WAIT_RSP, then a stale response.
        drv_instr(1'b1, 2'b01, 3'd2, 5'd11, 32'h4000);
        u_bus.mem_rsp_valid = 1'b0;
        tick();
        drv_none();
        tick();
        rst = 1'b0;
        tick();
        check("rstw_stall", 32'(u_bus.stall_req), 32'h0);
        rst = 1'b1;
        u_bus.mem_rsp_valid = 1'b1;
        tick();
        check("rstw_we", 32'(u_bus.wb_reg_write), 32'h0);

        // Flushed instruction produces no writeback.
        drv_instr(1'b0, 2'b00, 3'd0, 5'd8, 32'h88);
        u_bus.in_flush      = 1'b1;
        u_bus.mem_rsp_valid = 1'b0;
        tick();
        check("flush_we", 32'(u_bus.wb_reg_write), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic ld;
            rst = ($urandom_range(0, 199) != 0);
            ld  = 1'($urandom_range(0, 1));
            drv_instr(ld, ld ? 2'b01 : 2'($urandom), 3'($urandom), 5'($urandom), $urandom);
            u_bus.in_valid      = ($urandom_range(0, 3) != 0);
            u_bus.in_flush      = ($urandom_range(0, 7) == 0);
            u_bus.in_reg_write  = ($urandom_range(0, 7) != 0);
            u_bus.in_pc_plus4   = $urandom;
            u_bus.in_imm        = $urandom;
            u_bus.mem_rsp_valid = ($urandom_range(0, 4) == 0);
            u_bus.mem_rsp_data  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
